// File: rtl/ising_model_top.sv
// 2D toroidal Ising lattice: sequential Metropolis sweeps with LFSR-driven acceptance,
// launched by a prescaler, publishing energy, magnetization and smoothed stats per sweep.
module ising_model_top #(
    parameter int GRID_SIZE   = 8,
    parameter int TEMP_WIDTH  = 8,
    parameter int UPDATE_RATE = 100000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                enable,
    input  logic [TEMP_WIDTH-1:0]               temperature,
    input  logic [15:0]                         random_seed,
    output logic [GRID_SIZE-1:0][GRID_SIZE-1:0] spin_states,
    output logic signed [15:0]                  system_energy,
    output logic signed [15:0]                  system_magnetization,
    output logic                                update_tick,
    output logic [31:0]                         update_counter,
    output logic [7:0]                          avg_energy,
    output logic [7:0]                          avg_magnetization
);
    localparam int N  = GRID_SIZE;
    localparam int NN = N * N;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = (UPDATE_RATE > 1) ? $clog2(UPDATE_RATE) : 1;

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

    state_t        state, state_next;
    logic [PW-1:0] prescaler;
    logic [15:0]   lfsr;
    logic [IW-1:0] row, col;
    logic [IW-1:0] row_up, row_dn, col_lt, col_rt;
    logic          wrap, last_site, s_cur, flip;
    logic [2:0]    aligned;
    logic [7:0]    t8, p8, rnd;

    assign wrap      = (prescaler == PW'(UPDATE_RATE - 1));
    assign last_site = (row == IW'(N - 1)) && (col == IW'(N - 1));
    assign rnd       = lfsr[7:0];

    if (TEMP_WIDTH >= 8) begin : g_t_trunc
        assign t8 = temperature[7:0];
    end else begin : g_t_ext
        assign t8 = {{(8 - TEMP_WIDTH){1'b0}}, temperature};
    end

    // (T*T)>>8 never exceeds 254, so no explicit saturation is needed
    assign p8 = 8'((16'(t8) * 16'(t8)) >> 8);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wrap) state_next = SWEEP;
            SWEEP:   if (last_site) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else if (enable) state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            lfsr      <= (random_seed == 16'd0) ? 16'hACE1 : random_seed;
        end else if (enable) begin
            prescaler <= wrap ? '0 : prescaler + PW'(1);
            lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    always_comb begin
        row_up  = (row == '0) ? IW'(N - 1) : row - IW'(1);
        row_dn  = (row == IW'(N - 1)) ? '0 : row + IW'(1);
        col_lt  = (col == '0) ? IW'(N - 1) : col - IW'(1);
        col_rt  = (col == IW'(N - 1)) ? '0 : col + IW'(1);
        s_cur   = spin_states[row][col];
        // dE = 4*aligned - 8, so aligned <= 2 means the flip never costs energy
        aligned = 3'(spin_states[row_up][col] ~^ s_cur) + 3'(spin_states[row_dn][col] ~^ s_cur)
                + 3'(spin_states[row][col_lt] ~^ s_cur) + 3'(spin_states[row][col_rt] ~^ s_cur);
        flip    = (aligned <= 3'd2)
               || ((aligned == 3'd3) && (rnd < t8))
               || ((aligned == 3'd4) && (rnd < p8));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spin_states <= '1;
            row         <= '0;
            col         <= '0;
        end else if (enable && state == SWEEP) begin
            if (flip) spin_states[row][col] <= ~s_cur;
            if (col == IW'(N - 1)) begin
                col <= '0;
                row <= (row == IW'(N - 1)) ? '0 : row + IW'(1);
            end else begin
                col <= col + IW'(1);
            end
        end
    end

    logic [15:0]        up_count, diff_bonds;
    logic signed [15:0] e_calc, m_calc;
    logic signed [17:0] e_plus, m_plus;

    always_comb begin
        up_count   = '0;
        diff_bonds = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                up_count   = up_count + 16'(spin_states[i][j]);
                diff_bonds = diff_bonds + 16'(spin_states[i][j] ^ spin_states[i][(j + 1) % N])
                                        + 16'(spin_states[i][j] ^ spin_states[(i + 1) % N][j]);
            end
        end
        e_calc = 16'(2 * diff_bonds) - 16'(2 * NN);
        m_calc = 16'(2 * up_count) - 16'(NN);
        e_plus = 18'(e_calc) + 18'sd128;
        m_plus = 18'(m_calc) + 18'sd128;
    end

    function automatic logic [7:0] sat8(input logic signed [17:0] v);
        if (v < 18'sd0) return 8'd0;
        else if (v > 18'sd255) return 8'd255;
        else return v[7:0];
    endfunction

    function automatic logic [7:0] ema(input logic [7:0] avg, input logic [7:0] sample);
        logic signed [8:0] d;
        d = $signed({1'b0, sample}) - $signed({1'b0, avg});
        return avg + 8'(d >>> 3);
    endfunction

    // update_tick is a one-cycle valid with no ready: every statistic output is already
    // updated in the cycle it is high and holds until the next completed sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            system_energy        <= 16'(-2 * NN);
            system_magnetization <= 16'(NN);
            update_tick          <= 1'b0;
            update_counter       <= '0;
            avg_energy           <= 8'd128;
            avg_magnetization    <= 8'd128;
        end else begin
            update_tick <= enable && (state == DONE);
            if (enable && state == DONE) begin
                system_energy        <= e_calc;
                system_magnetization <= m_calc;
                update_counter       <= update_counter + 32'd1;
                avg_energy           <= ema(avg_energy, sat8(e_plus));
                avg_magnetization    <= ema(avg_magnetization, sat8(m_plus));
            end
        end
    end

endmodule

// File: tb/tb_ising_model_top.sv
// Bench for ising_model_top: a lattice model predicts each sweep's outcome at the prescaler
// wrap and queues it; a monitor pops and compares whenever update_tick is seen.
module tb_ising_model_top;
    localparam int N    = 4;
    localparam int NN   = N * N;
    localparam int RATE = 100;

    logic                 clk;
    logic                 rst_n;
    logic                 enable;
    logic [7:0]           temperature;
    logic [15:0]          random_seed;
    logic [N-1:0][N-1:0]  spin_states;
    logic signed [15:0]   system_energy;
    logic signed [15:0]   system_magnetization;
    logic                 update_tick;
    logic [31:0]          update_counter;
    logic [7:0]           avg_energy;
    logic [7:0]           avg_magnetization;

    ising_model_top #(
        .GRID_SIZE  (N),
        .TEMP_WIDTH (8),
        .UPDATE_RATE(RATE)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .temperature         (temperature),
        .random_seed         (random_seed),
        .spin_states         (spin_states),
        .system_energy       (system_energy),
        .system_magnetization(system_magnetization),
        .update_tick         (update_tick),
        .update_counter      (update_counter),
        .avg_energy          (avg_energy),
        .avg_magnetization   (avg_magnetization)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int en_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [NN-1:0] spins;
        int e;
        int m;
        int cnt;
        int ae;
        int am;
        int due;
    } exp_t;

    exp_t exp_q[$];

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic int calc_e(input logic [N-1:0][N-1:0] l);
        int e;
        e = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                e += (l[i][j] == l[i][(j + 1) % N]) ? -1 : 1;
                e += (l[i][j] == l[(i + 1) % N][j]) ? -1 : 1;
            end
        return e;
    endfunction

    function automatic int calc_m(input logic [N-1:0][N-1:0] l);
        int m;
        m = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m += l[i][j] ? 1 : -1;
        return m;
    endfunction

    function automatic logic [N-1:0][N-1:0] run_sweep(input logic [N-1:0][N-1:0] lat_in,
                                                      input logic [15:0] l0, input int t);
        logic [N-1:0][N-1:0] l;
        logic [15:0] lf;
        int a, de, thr8, rnd;
        logic s;
        l  = lat_in;
        lf = l0;
        thr8 = (t * t) >> 8;
        if (thr8 > 255) thr8 = 255;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                s   = l[r][c];
                rnd = int'(lf[7:0]);
                a   = 0;
                if (l[(r + N - 1) % N][c] == s) a++;
                if (l[(r + 1) % N][c] == s) a++;
                if (l[r][(c + N - 1) % N] == s) a++;
                if (l[r][(c + 1) % N] == s) a++;
                de = 4 * a - 8;
                if (de <= 0 || (de == 4 && rnd < t) || (de == 8 && rnd < thr8))
                    l[r][c] = ~s;
                lf = lfsr_step(lf);
            end
        return l;
    endfunction

    function automatic int sat_ema(input int avg, input int v);
        int s;
        s = v + 128;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return avg + ((s - avg) >>> 3);
    endfunction

    logic [N-1:0][N-1:0] m_lat;
    logic [15:0]         m_lfsr;
    int                  m_pre, m_cnt, m_ae, m_am;

    always @(posedge clk) begin
        exp_t x;
        if (!rst_n) begin
            m_lat  = '1;
            m_lfsr = (random_seed == 16'd0) ? 16'hACE1 : random_seed;
            m_pre  = 0;
            m_cnt  = 0;
            m_ae   = 128;
            m_am   = 128;
            exp_q.delete();
        end else if (enable) begin
            en_cnt++;
            m_lfsr = lfsr_step(m_lfsr);
            if (m_pre == RATE - 1) begin
                m_pre = 0;
                m_lat = run_sweep(m_lat, m_lfsr, int'(temperature));
                m_cnt++;
                x.spins = m_lat;
                x.e     = calc_e(m_lat);
                x.m     = calc_m(m_lat);
                m_ae    = sat_ema(m_ae, x.e);
                m_am    = sat_ema(m_am, x.m);
                x.cnt   = m_cnt;
                x.ae    = m_ae;
                x.am    = m_am;
                x.due   = en_cnt + NN + 1;
                exp_q.push_back(x);
            end else begin
                m_pre++;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t x;
        int e_now, m_now;
        if (rst_n && update_tick) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_tick", 1, 0);
            end else begin
                x = exp_q.pop_front();
                e_now = calc_e(spin_states);
                m_now = calc_m(spin_states);
                chk("tick_time", en_cnt, x.due);
                chk("spins", spin_states, x.spins);
                chk("energy", system_energy, x.e);
                chk("magnetization", system_magnetization, x.m);
                chk("counter", update_counter, x.cnt);
                chk("avg_energy", avg_energy, x.ae);
                chk("avg_magnetization", avg_magnetization, x.am);
                chk("energy_vs_lattice", system_energy, e_now);
                chk("mag_vs_lattice", system_magnetization, m_now);
                chk("energy_invariant", (system_energy >= -2 * NN) && (system_energy <= 2 * NN)
                    && ((int'(system_energy) + 2 * NN) % 4 == 0), 1);
                chk("mag_invariant", (system_magnetization >= -NN) && (system_magnetization <= NN)
                    && ((int'(system_magnetization) + NN) % 2 == 0), 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ticks(input int n);
        int seen, budget;
        seen   = 0;
        budget = n * 150 + 700;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            if (update_tick) seen++;
            budget--;
        end
        chk("tick_wait", seen, n);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_spins"}, spin_states, 16'hFFFF);
        chk({tag, "_energy"}, system_energy, -32);
        chk({tag, "_mag"}, system_magnetization, 16);
        chk({tag, "_counter"}, update_counter, 0);
        chk({tag, "_tick"}, update_tick, 0);
        chk({tag, "_avg_e"}, avg_energy, 128);
        chk({tag, "_avg_m"}, avg_magnetization, 128);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [N-1:0][N-1:0] snap_spins;
        logic [31:0]         snap_cnt;
        logic signed [15:0]  snap_e, snap_m;
        logic [7:0]          snap_ae, snap_am;
        int                  paused_ticks;

        rst_n       = 1'b0;
        enable      = 1'b0;
        temperature = 8'h00;
        random_seed = 16'h1234;
        repeat (4) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // zero temperature: lattice stays all up, averages drift by hand-computed steps
        enable = 1'b1;
        wait_ticks(3);
        chk("t0_spins", spin_states, 16'hFFFF);
        chk("t0_energy", system_energy, -32);
        chk("t0_mag", system_magnetization, 16);
        chk("t0_counter", update_counter, 3);
        chk("t0_avg_e", avg_energy, 117);
        chk("t0_avg_m", avg_magnetization, 132);

        temperature = 8'h20;
        wait_ticks(10);
        temperature = 8'h80;
        wait_ticks(10);
        temperature = 8'h08;
        wait_ticks(10);

        // freeze mid-sweep
        temperature = 8'h80;
        wait_ticks(1);
        repeat (90) @(negedge clk);
        enable       = 1'b0;
        snap_spins   = spin_states;
        snap_cnt     = update_counter;
        snap_e       = system_energy;
        snap_m       = system_magnetization;
        snap_ae      = avg_energy;
        snap_am      = avg_magnetization;
        paused_ticks = 0;
        repeat (500) begin
            @(negedge clk);
            if (update_tick) paused_ticks++;
        end
        chk("pause_ticks", paused_ticks, 0);
        chk("pause_spins", spin_states, snap_spins);
        chk("pause_counter", update_counter, snap_cnt);
        chk("pause_energy", system_energy, snap_e);
        chk("pause_mag", system_magnetization, snap_m);
        chk("pause_avg_e", avg_energy, snap_ae);
        chk("pause_avg_m", avg_magnetization, snap_am);
        enable = 1'b1;
        wait_ticks(2);

        // asynchronous reset mid-sweep with a zero seed
        temperature = 8'h20;
        wait_ticks(1);
        repeat (90) @(negedge clk);
        random_seed = 16'h0000;
        rst_n = 1'b0;
        #1;
        check_reset_values("midsweep_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(5);

        temperature = 8'hFF;
        wait_ticks(3);

        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ising_model_top.md
Name: ising_model_top

Overview:
Hardware 2D Ising-model Monte Carlo engine: a GRID_SIZE x GRID_SIZE toroidal lattice of ±1 spins updated by sequential Metropolis sweeps driven by an internal 16-bit LFSR. A prescaler launches one full-lattice sweep every UPDATE_RATE enabled cycles. After each sweep it publishes the lattice, total energy, magnetization, a sweep counter and 8-bit smoothed statistics. It is the top of the Ising simulation core, driven by a host or UI supplying temperature and seed.

Parameters:
GRID_SIZE, 8, lattice edge length N (≥2); periodic boundaries.
TEMP_WIDTH, 8, temperature input width.
UPDATE_RATE, 100000, enabled clock cycles between sweep launches; must be ≥ N²+2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
enable  input  1  run enable; low freezes all state.
temperature  input  TEMP_WIDTH  kT in units of J/32 (0x20 = 1.0).
random_seed  input  16  LFSR seed, sampled during reset.
spin_states  output  [N-1:0][N-1:0]  spin_states[i][j] = row i, column j; 1 = up (+1), 0 = down (−1).
system_energy  output  signed 16  E = −Σ s·s over right and down bonds, wrapped.
system_magnetization  output  signed 16  M = Σ s = 2·popcount − N².
update_tick  output  1  one-cycle pulse per completed sweep.
update_counter  output  32  completed sweeps, wraps at 2^32.
avg_energy  output  8  EMA of energy sample.
avg_magnetization  output  8  EMA of magnetization sample.

Behaviour:
- Reset, asynchronous, immediate, including mid-sweep:
  - all spins = 1; system_energy = −2N²; system_magnetization = +N².
  - update_tick = 0; update_counter = 0; avg_energy = avg_magnetization = 128.
  - prescaler = 0; FSM = IDLE; LFSR = random_seed, or 0xACE1 if seed is 0.
- LFSR: Fibonacci x^16+x^14+x^13+x^11+1. Advances every clock with enable=1. rand = lfsr[7:0].
- enable=0: prescaler, FSM, LFSR, spins and outputs hold; update_tick = 0.
- Prescaler: counts enabled cycles 0..UPDATE_RATE−1. On wrap, with FSM in IDLE, go to SWEEP. A wrap during SWEEP or DONE is ignored.
- SWEEP: exactly N² enabled cycles, one site per cycle, row-major (0,0),(0,1)…(N−1,N−1).
  - Updates are in place; later sites see already-updated neighbours.
  - nsum = sum of the 4 wrapped neighbours (−4..4); dE = 2·s·nsum ∈ {−8,−4,0,4,8}.
  - Flip if dE ≤ 0.
  - dE = 4: flip iff rand < min(255, T).
  - dE = 8: flip iff rand < (T·T)>>8, saturated to 255.
  - T = temperature, zero-extended or truncated to 8 bits. Sampled at each site, so changes apply from the next site.
- DONE: one cycle, then return to IDLE. On that edge, all of the following update together:
  - system_energy and system_magnetization recomputed from the final lattice.
  - update_counter += 1; update_tick = 1 for that single cycle.
  - sample_e = sat0..255(E+128); avg_energy += (sample_e − avg_energy) >>> 3 (arithmetic).
  - sample_m = sat0..255(M+128); avg_magnetization likewise.
  - Outputs are already valid when update_tick rises.
- spin_states reflects the live lattice every cycle. Energy and magnetization change only in DONE.
- Steady-state tick spacing is exactly UPDATE_RATE enabled cycles. The first tick is N²+1 edges after the first prescaler wrap.
- Invariants:
  - −2N² ≤ E ≤ 2N² and E ≡ 2N² (mod 4).
  - |M| ≤ N² and M ≡ N² (mod 2).

Test Plan:
1. N=4, UPDATE_RATE=100, seed 0x1234; hold reset → spin_states=16'hFFFF, energy −32, magnetization 16, counter 0, avgs 128, tick 0.
2. temperature=0, enable → no flips; every tick: energy −32, magnetization 16, counter 1,2,3…; ticks 100 cycles apart, first tick 17 edges after first wrap; avg_energy moves 128→124→120… toward 96, avg_magnetization 128→130… toward 144.
3. temperature 0x20, then 0x80, then 0x08, 10 ticks each → each tick: energy and magnetization equal values recomputed from spin_states; invariants hold; counter strictly +1 per tick; bit-exact match against a reference model using seed 0x1234.
4. temperature 0xFF → high flip rate; mean |M| over 10 sweeps clearly below 16; invariants hold.
5. Drop enable for 500 cycles mid-sweep → no tick, all outputs and spins frozen; re-enable → sweep resumes at the same site.
6. Assert rst_n mid-sweep with seed 0 → immediate reset values; LFSR = 0xACE1; the sequence after release matches a seed-0xACE1 reference run.
